// File: rtl/rx_uart_param.sv
// Parametrised UART receiver: 2-FF sync, 3-sample majority vote, false-start
// rejection, framing check; optional parity checker enabled by macro RX_PARITY_EN.
module rx_uart_param #(
   parameter int CLKS_PER_BIT = 200,
   parameter int DATA_BITS    = 8,
   parameter int STOP_BITS    = 1,
   parameter int PARITY_ODD   = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rx_in,
   input  logic                 rx_enable_signal,
   output logic                 rx_done_signal,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_frame_err,
`ifdef RX_PARITY_EN
   output logic                 rx_parity_err,
`endif
   output logic                 rx_busy
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int IW = $clog2(DATA_BITS);
   localparam logic [CW-1:0] LAST_CNT  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] MID_CNT   = CW'(CLKS_PER_BIT / 2);
   localparam logic [IW-1:0] LAST_DATA = IW'(DATA_BITS - 1);
   localparam logic          LAST_STOP = (STOP_BITS == 2);

   generate
      if (CLKS_PER_BIT < 8 || DATA_BITS < 5 || DATA_BITS > 9 ||
          (STOP_BITS != 1 && STOP_BITS != 2) || (PARITY_ODD != 0 && PARITY_ODD != 1)) begin : g_badParam
         $error("rx_uart_param: illegal parameter value");
      end
   endgenerate

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_START     = 3'd1,
      S_DATA      = 3'd2,
`ifdef RX_PARITY_EN
      S_PARITY    = 3'd3,
`endif
      S_STOP      = 3'd4,
      S_WAIT_HIGH = 3'd5
   } state_t;

   state_t                r_state;
   logic [1:0]            r_sync;
   logic [1:0]            r_hist;
   logic [CW-1:0]         r_cnt;
   logic [IW-1:0]         r_bitIdx;
   logic                  r_stopIdx;
   logic                  r_stopBad;
   logic [DATA_BITS-1:0]  r_shift;
   logic [DATA_BITS-1:0]  r_data;
   logic                  r_done;
   logic                  r_ferr;
   logic                  r_busy;
`ifdef RX_PARITY_EN
   logic                  r_parBad;
   logic                  r_perr;
   logic                  w_parExp;
`endif
   logic                  w_rxs;
   logic                  w_maj;
   logic                  w_sample;

   // r_hist holds rxs from the two previous cycles, so at T+1 the vote sees T-1, T, T+1
   assign w_rxs    = r_sync[1];
   assign w_maj    = (r_hist[1] & r_hist[0]) | (r_hist[1] & w_rxs) | (r_hist[0] & w_rxs);
   assign w_sample = (r_cnt == MID_CNT);
`ifdef RX_PARITY_EN
   assign w_parExp = (PARITY_ODD != 0) ? ~^r_shift : ^r_shift;
`endif

   // The bit counter free-runs modulo CLKS_PER_BIT once a start is seen, so every
   // decision lands exactly one bit period after the previous one.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_sync    <= 2'b11;
         r_hist    <= 2'b11;
         r_cnt     <= '0;
         r_bitIdx  <= '0;
         r_stopIdx <= 1'b0;
         r_stopBad <= 1'b0;
         r_shift   <= '0;
         r_data    <= '0;
         r_done    <= 1'b0;
         r_ferr    <= 1'b0;
         r_busy    <= 1'b0;
`ifdef RX_PARITY_EN
         r_parBad  <= 1'b0;
         r_perr    <= 1'b0;
`endif
      end else begin
         r_sync <= {r_sync[0], rx_in};
         r_hist <= {r_hist[0], w_rxs};
         r_done <= 1'b0;
         r_ferr <= 1'b0;
`ifdef RX_PARITY_EN
         r_perr <= 1'b0;
`endif
         if (r_state != S_IDLE) begin
            r_cnt <= (r_cnt == LAST_CNT) ? '0 : r_cnt + CW'(1);
         end
         if (!rx_enable_signal) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (!w_rxs) begin
                     r_state <= S_START;
                     r_busy  <= 1'b1;
                     r_cnt   <= '0;
                  end
               end
               S_START: begin
                  if (w_sample) begin
                     if (w_maj) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                     end else begin
                        r_state  <= S_DATA;
                        r_bitIdx <= '0;
                     end
                  end
               end
               S_DATA: begin
                  if (w_sample) begin
                     r_shift <= {w_maj, r_shift[DATA_BITS-1:1]};
                     if (r_bitIdx == LAST_DATA) begin
                        r_stopIdx <= 1'b0;
                        r_stopBad <= 1'b0;
`ifdef RX_PARITY_EN
                        r_state   <= S_PARITY;
`else
                        r_state   <= S_STOP;
`endif
                     end else begin
                        r_bitIdx <= r_bitIdx + IW'(1);
                     end
                  end
               end
`ifdef RX_PARITY_EN
               S_PARITY: begin
                  if (w_sample) begin
                     r_parBad <= (w_maj != w_parExp);
                     r_state  <= S_STOP;
                  end
               end
`endif
               S_STOP: begin
                  if (w_sample) begin
                     if (r_stopIdx == LAST_STOP) begin
                        r_done <= 1'b1;
                        r_data <= r_shift;
                        r_ferr <= r_stopBad | ~w_maj;
`ifdef RX_PARITY_EN
                        r_perr <= r_parBad;
`endif
                        // A low stop bit may be a break; wait for the line to recover
                        if (r_stopBad | ~w_maj) begin
                           r_state <= S_WAIT_HIGH;
                        end else begin
                           r_state <= S_IDLE;
                           r_busy  <= 1'b0;
                        end
                     end else begin
                        r_stopBad <= r_stopBad | ~w_maj;
                        r_stopIdx <= 1'b1;
                     end
                  end
               end
               S_WAIT_HIGH: begin
                  if (w_rxs) begin
                     r_state <= S_IDLE;
                     r_busy  <= 1'b0;
                  end
               end
               default: begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign rx_done_signal = r_done;
   assign rx_data        = r_data;
   assign rx_frame_err   = r_ferr;
   assign rx_busy        = r_busy;
`ifdef RX_PARITY_EN
   assign rx_parity_err  = r_perr;
`endif

endmodule

// File: tb/tb_rx_uart_param.sv
// Scoreboard bench for rx_uart_param: default 8N1 instance plus a 7-data/2-stop
// instance; parity frames are exercised when RX_PARITY_EN is defined.
module tb_rx_uart_param;

   localparam int CPB_A = 200;
   localparam int CPB_B = 16;

   typedef struct {
      logic [8:0] data;
      logic       ferr;
      logic       perr;
      int         when;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       rxA;
   logic       rxB;
   logic       rxEnable;
   logic       rx_done_signal_a;
   logic [7:0] rx_data_a;
   logic       rx_frame_err_a;
   logic       rx_busy_a;
   logic       rx_done_signal_b;
   logic [6:0] rx_data_b;
   logic       rx_frame_err_b;
   logic       rx_busy_b;
`ifdef RX_PARITY_EN
   logic       rx_parity_err_a;
   logic       rx_parity_err_b;
`endif

   int         cycleCnt = 0;
   int         checkCount = 0;
   int         passCount = 0;
   exp_t       qA[$];
   exp_t       qB[$];
   logic       prevDoneA = 1'b0;
   logic       prevDoneB = 1'b0;
   int         lastDoneA = 0;
   int         prevDoneAtA = 0;
   logic [8:0] expHeldData;

   rx_uart_param dutA (
      .clk              (clk),
      .rst              (rst),
      .rx_in            (rxA),
      .rx_enable_signal (rxEnable),
      .rx_done_signal   (rx_done_signal_a),
      .rx_data          (rx_data_a),
      .rx_frame_err     (rx_frame_err_a),
`ifdef RX_PARITY_EN
      .rx_parity_err    (rx_parity_err_a),
`endif
      .rx_busy          (rx_busy_a)
   );

   rx_uart_param #(.CLKS_PER_BIT(CPB_B), .DATA_BITS(7), .STOP_BITS(2)) dutB (
      .clk              (clk),
      .rst              (rst),
      .rx_in            (rxB),
      .rx_enable_signal (rxEnable),
      .rx_done_signal   (rx_done_signal_b),
      .rx_data          (rx_data_b),
      .rx_frame_err     (rx_frame_err_b),
`ifdef RX_PARITY_EN
      .rx_parity_err    (rx_parity_err_b),
`endif
      .rx_busy          (rx_busy_b)
   );

   // Free-running clock and a posedge count used to time-stamp expected done pulses
   always #5 clk = ~clk;
   always @(posedge clk) cycleCnt <= cycleCnt + 1;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed === expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Monitor for the 8N1 instance: every done pulse must match the head of its queue
   always @(negedge clk) begin
      exp_t e;
      if (rx_done_signal_a === 1'b1) begin
         checkOutput("doneExpectedA", 32'(qA.size() != 0), 32'd1);
         if (qA.size() != 0) begin
            e = qA.pop_front();
            checkOutput("dataA", 32'(rx_data_a), 32'(e.data));
            checkOutput("frameErrA", 32'(rx_frame_err_a), 32'(e.ferr));
`ifdef RX_PARITY_EN
            checkOutput("parityErrA", 32'(rx_parity_err_a), 32'(e.perr));
`endif
            checkOutput("doneCycleA", 32'(cycleCnt), 32'(e.when));
         end
         prevDoneAtA = lastDoneA;
         lastDoneA   = cycleCnt;
      end else if (prevDoneA) begin
         checkOutput("frameErrClearedA", 32'(rx_frame_err_a), 32'd0);
      end
      prevDoneA = rx_done_signal_a;
   end

   // Monitor for the 7-data/2-stop instance
   always @(negedge clk) begin
      exp_t e;
      if (rx_done_signal_b === 1'b1) begin
         checkOutput("doneExpectedB", 32'(qB.size() != 0), 32'd1);
         if (qB.size() != 0) begin
            e = qB.pop_front();
            checkOutput("dataB", 32'(rx_data_b), 32'(e.data));
            checkOutput("frameErrB", 32'(rx_frame_err_b), 32'(e.ferr));
`ifdef RX_PARITY_EN
            checkOutput("parityErrB", 32'(rx_parity_err_b), 32'(e.perr));
`endif
            checkOutput("doneCycleB", 32'(cycleCnt), 32'(e.when));
         end
      end else if (prevDoneB) begin
         checkOutput("frameErrClearedB", 32'(rx_frame_err_b), 32'd0);
      end
      prevDoneB = rx_done_signal_b;
   end

   task automatic driveLine(input bit sel, input logic v);
      if (sel) rxB = v;
      else     rxA = v;
   endtask

   // Sends one frame starting at the current negedge; parSel 0/1 forces the parity
   // bit, 2 sends the correct even parity. abortBit >= 0 kills the frame at that bit.
   task automatic applyStimulus(input bit sel, input logic [8:0] data, input logic [1:0] stopVals,
                                input int parSel, input logic expFerr, input logic expPerr,
                                input logic [15:0] spikeMask, input int abortBit, input bit abortByRst);
      int         nData;
      int         nStop;
      int         cpb;
      int         n;
      logic [15:0] bits;
      logic [8:0] dm;
      exp_t       e;
      nData = sel ? 7 : 8;
      nStop = sel ? 2 : 1;
      cpb   = sel ? CPB_B : CPB_A;
      dm    = data & 9'((1 << nData) - 1);
      bits  = '0;
      n     = 1;
      for (int i = 0; i < nData; i++) begin
         bits[n] = dm[i];
         n++;
      end
`ifdef RX_PARITY_EN
      bits[n] = (parSel == 2) ? ^dm : parSel[0];
      n++;
`endif
      for (int i = 0; i < nStop; i++) begin
         bits[n] = stopVals[i];
         n++;
      end
      if (abortBit < 0) begin
         e.data = dm;
         e.ferr = expFerr;
         e.perr = expPerr;
         e.when = cycleCnt + 4 + cpb / 2 + (n - 1) * cpb;
         if (sel) qB.push_back(e);
         else     qA.push_back(e);
      end
      for (int b = 0; b < n; b++) begin
         driveLine(sel, bits[b]);
         if (b == abortBit) begin
            checkOutput("busyBeforeAbort", 32'(rx_busy_a), 32'd1);
            if (abortByRst) rst = 1'b1;
            else            rxEnable = 1'b0;
         end
         for (int j = 0; j < cpb; j++) begin
            if (spikeMask[b] && j == cpb / 2)          driveLine(sel, ~bits[b]);
            else if (spikeMask[b] && j == cpb / 2 + 1) driveLine(sel, bits[b]);
            @(negedge clk);
            if (b == abortBit && j == 0) begin
               checkOutput("busyAfterAbort", 32'(rx_busy_a), 32'd0);
               checkOutput("dataAfterAbort", 32'(rx_data_a), abortByRst ? 32'd0 : 32'(expHeldData));
            end
         end
      end
      if (abortBit >= 0) begin
         rst      = 1'b0;
         rxEnable = 1'b1;
         driveLine(sel, 1'b1);
      end
   endtask

   initial begin
      rst      = 1'b1;
      rxA      = 1'b1;
      rxB      = 1'b1;
      rxEnable = 1'b1;
      expHeldData = '0;
      repeat (4) @(negedge clk);
      checkOutput("resetDoneA", 32'(rx_done_signal_a), 32'd0);
      checkOutput("resetDataA", 32'(rx_data_a), 32'd0);
      checkOutput("resetFerrA", 32'(rx_frame_err_a), 32'd0);
      checkOutput("resetBusyA", 32'(rx_busy_a), 32'd0);
      checkOutput("resetDataB", 32'(rx_data_b), 32'd0);
      checkOutput("resetBusyB", 32'(rx_busy_b), 32'd0);
      rst = 1'b0;
      repeat (5) @(negedge clk);

      applyStimulus(1'b0, 9'h55, 2'b11, 2, 1'b0, 1'b0, 16'h0, -1, 1'b0);
      repeat (20) @(negedge clk);

      // 50-clock low glitch must be rejected as a false start
      rxA = 1'b0;
      for (int j = 0; j < 50; j++) begin
         @(negedge clk);
         if (j == 20) checkOutput("busyDuringGlitch", 32'(rx_busy_a), 32'd1);
      end
      rxA = 1'b1;
      repeat (CPB_A) @(negedge clk);
      checkOutput("busyAfterGlitch", 32'(rx_busy_a), 32'd0);
      checkOutput("dataAfterGlitch", 32'(rx_data_a), 32'h55);

      // Low stop bit followed by a held break; no new start until line goes high
      applyStimulus(1'b0, 9'hC3, 2'b00, 2, 1'b1, 1'b0, 16'h0, -1, 1'b0);
      repeat (3 * CPB_A) @(negedge clk);
      checkOutput("busyInBreak", 32'(rx_busy_a), 32'd1);
      rxA = 1'b1;
      repeat (10) @(negedge clk);
      checkOutput("busyAfterBreak", 32'(rx_busy_a), 32'd0);
      applyStimulus(1'b0, 9'h12, 2'b11, 2, 1'b0, 1'b0, 16'h0, -1, 1'b0);
      repeat (20) @(negedge clk);

      applyStimulus(1'b0, 9'hA5, 2'b11, 2, 1'b0, 1'b0, 16'h0, -1, 1'b0);
      applyStimulus(1'b0, 9'h3C, 2'b11, 2, 1'b0, 1'b0, 16'h0, -1, 1'b0);
      checkOutput("backToBackSpacing", 32'(lastDoneA - prevDoneAtA), 32'(10 * CPB_A));
      repeat (20) @(negedge clk);

      applyStimulus(1'b0, 9'h0F, 2'b11, 2, 1'b0, 1'b0, 16'h0084, -1, 1'b0);
      repeat (20) @(negedge clk);

      expHeldData = 9'h0F;
      applyStimulus(1'b0, 9'hAA, 2'b11, 2, 1'b0, 1'b0, 16'h0, 4, 1'b0);
      repeat (20) @(negedge clk);
      applyStimulus(1'b0, 9'h81, 2'b11, 2, 1'b0, 1'b0, 16'h0, -1, 1'b0);
      repeat (20) @(negedge clk);
      applyStimulus(1'b0, 9'hAA, 2'b11, 2, 1'b0, 1'b0, 16'h0, 4, 1'b1);
      repeat (20) @(negedge clk);
      applyStimulus(1'b0, 9'h7E, 2'b11, 2, 1'b0, 1'b0, 16'h0, -1, 1'b0);
      repeat (20) @(negedge clk);

`ifdef RX_PARITY_EN
      applyStimulus(1'b0, 9'h07, 2'b11, 0, 1'b0, 1'b1, 16'h0, -1, 1'b0);
      repeat (20) @(negedge clk);
      applyStimulus(1'b0, 9'h07, 2'b11, 1, 1'b0, 1'b0, 16'h0, -1, 1'b0);
      repeat (20) @(negedge clk);
`endif

      applyStimulus(1'b1, 9'h5A, 2'b11, 2, 1'b0, 1'b0, 16'h0, -1, 1'b0);
      repeat (20) @(negedge clk);
      applyStimulus(1'b1, 9'h5A, 2'b01, 2, 1'b1, 1'b0, 16'h0, -1, 1'b0);
      repeat (3 * CPB_B) @(negedge clk);
      rxB = 1'b1;
      repeat (10) @(negedge clk);
      checkOutput("busyAfterBreakB", 32'(rx_busy_b), 32'd0);
      applyStimulus(1'b1, 9'h33, 2'b11, 2, 1'b0, 1'b0, 16'h0, -1, 1'b0);

      repeat (50) @(negedge clk);
      checkOutput("pendingFramesA", 32'(qA.size()), 32'd0);
      checkOutput("pendingFramesB", 32'(qB.size()), 32'd0);
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
